wb_host_master: RTL

WB_HOST_MASTER -- requirements
Module: wb_host_master

---
 rtl/wb_host_pkg.sv | 19 +
 rtl/wb_host_master.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wb_host_pkg.sv
// Shared definitions for the Wishbone host master.
// Holds the FSM state encoding, Wishbone bus widths and the default
// read-data pattern returned when a read times out.
package wb_host_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int CNT_W    = 16;

  localparam logic [WB_DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : wb_host_pkg

// File: rtl/wb_host_master.sv
// Wishbone classic single-transaction host master.
// A command (we/adr/dat/sel) is accepted in IDLE, issued on the bus for as
// long as it takes the responder to ack, and the result is held on the
// response port until consumed.
//
// Optional feature: define WB_HOST_MASTER_TIMEOUT_EN to enable the bus
// wait counter. When enabled, a transaction with no ack after
// TIMEOUT_CYCLES bus cycles is aborted and answered with rsp_err_o = 1
// (read data ERR_DATA). When undefined the master waits for ack forever
// and rsp_err_o is tied low.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i          command payload
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_dat_o, rsp_err_o          response payload (data 0 for writes)
//   wbm_cyc_o ... wbm_dat_o       Wishbone initiator outputs
//   wbm_ack_i, wbm_dat_i          Wishbone responder inputs
//   busy_o                        high whenever not IDLE
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int unsigned          TIMEOUT_CYCLES = 255,
  parameter logic [WB_DAT_W-1:0]  ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  output logic                busy_o
);

  state_t                state_reg, state_next;
  logic                  we_reg, we_next;
  logic [WB_ADR_W-1:0]   adr_reg, adr_next;
  logic [WB_DAT_W-1:0]   dat_reg, dat_next;
  logic [WB_SEL_W-1:0]   sel_reg, sel_next;
  logic [WB_DAT_W-1:0]   rsp_dat_reg, rsp_dat_next;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  // Counter holds (bus cycles elapsed - 1); the last permitted cycle is
  // the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  rsp_err_reg, rsp_err_next;
`endif

  // Next-state and datapath-next logic.
  always_comb begin
    state_next   = state_reg;
    we_next      = we_reg;
    adr_next     = adr_reg;
    dat_next     = dat_reg;
    sel_next     = sel_reg;
    rsp_dat_next = rsp_dat_reg;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
    cnt_next     = '0;
    rsp_err_next = rsp_err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_next    = cmd_we_i;
          adr_next   = cmd_adr_i;
          // Reads never present write data on the bus.
          dat_next   = cmd_we_i ? cmd_dat_i : '0;
          sel_next   = cmd_sel_i;
          state_next = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (wbm_ack_i) begin
          rsp_dat_next = we_reg ? '0 : wbm_dat_i;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
          rsp_err_next = 1'b0;
`endif
          state_next   = ST_RESP;
        end
`ifdef WB_HOST_MASTER_TIMEOUT_EN
        else if (cnt_reg == CNT_LAST) begin
          rsp_dat_next = we_reg ? '0 : ERR_DATA;
          rsp_err_next = 1'b1;
          state_next   = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        // Returning to IDLE here means the next command is only accepted
        // one cycle after the response is consumed.
        if (rsp_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg   <= ST_IDLE;
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      sel_reg     <= '0;
      rsp_dat_reg <= '0;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
      cnt_reg     <= '0;
      rsp_err_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      we_reg      <= we_next;
      adr_reg     <= adr_next;
      dat_reg     <= dat_next;
      sel_reg     <= sel_next;
      rsp_dat_reg <= rsp_dat_next;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
      cnt_reg     <= cnt_next;
      rsp_err_reg <= rsp_err_next;
`endif
    end
  end

  // cyc/stb come straight from the state register, so they are glitch
  // free and drop the cycle after ack, timeout or reset.
  assign wbm_cyc_o   = (state_reg == ST_BUS);
  assign wbm_stb_o   = (state_reg == ST_BUS);
  assign wbm_we_o    = we_reg;
  assign wbm_adr_o   = adr_reg;
  assign wbm_dat_o   = dat_reg;
  assign wbm_sel_o   = sel_reg;

  assign cmd_ready_o = (state_reg == ST_IDLE);
  assign busy_o      = (state_reg != ST_IDLE);
  assign rsp_valid_o = (state_reg == ST_RESP);
  assign rsp_dat_o   = rsp_dat_reg;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_reg;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule : wb_host_master
